// File: rtl/aff_filt_pkg.sv
// Shared widths, negative-tap masks, stage payloads and clip helper for the 8-tap affine filter.
package aff_filt_pkg;

    localparam int unsigned PW    = 14;
    localparam int unsigned SW    = 8;
    localparam int unsigned AW    = 18;
    localparam int unsigned SHIFT = 6;
    localparam int unsigned NTAP  = 8;

    // Row f holds the negative-tap mask for fractional position f; bit t set means tap t is negated.
    localparam logic [15:0][7:0] TAP_NEG = {
        8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4,
        8'hA5,
        8'h25, 8'h25, 8'h25, 8'h25, 8'h25, 8'h25, 8'h25,
        8'h00
    };

    localparam logic signed [AW-1:0] PIX_MAX = AW'((1 << (SW - 1)) - 1);
    localparam logic signed [AW-1:0] PIX_MIN = ~PIX_MAX;

    typedef struct packed {
        logic                  frac0;
        logic [SW-1:0]         ctr;
        logic [3:0][AW-1:0]    sum;
    } s1_t;

    typedef struct packed {
        logic                  frac0;
        logic [SW-1:0]         ctr;
        logic [1:0][AW-1:0]    sum;
    } s2_t;

    function automatic logic [SW-1:0] clip_pix(input logic signed [AW-1:0] r);
        if (r > PIX_MAX) begin
            return SW'(PIX_MAX);
        end
        if (r < PIX_MIN) begin
            return SW'(PIX_MIN);
        end
        return SW'(r);
    endfunction

    function automatic logic is_clip(input logic signed [AW-1:0] r);
        return (r > PIX_MAX) || (r < PIX_MIN);
    endfunction

endpackage

// File: rtl/aff_round_clip.sv
// Round, arithmetic shift and clip of the accumulated sum down to one signed sample.
// Exposes the clipped flag only when AFF_SAT_CNT_EN is defined.
module aff_round_clip
    import aff_filt_pkg::*;
(
    input  logic [AW-1:0] sum_i,
    output logic [SW-1:0] pix_c
`ifdef AFF_SAT_CNT_EN
    ,
    output logic          clip_c
`endif
);

    logic signed [AW-1:0] rnd_c;
    logic signed [AW-1:0] r_c;

    always_comb begin
        rnd_c = $signed(sum_i) + $signed(AW'(1 << (SHIFT - 1)));
        r_c   = rnd_c >>> SHIFT;
        pix_c = clip_pix(r_c);
    end

`ifdef AFF_SAT_CNT_EN
    assign clip_c = is_clip(r_c);
`endif

endmodule

// File: rtl/aff8_tap_accum.sv
// Signed 8-tap product accumulator: sign, 3-stage adder tree, round/shift/clip, frac=0 bypass.
// Optional clipped-result counter on sat_cnt_o when AFF_SAT_CNT_EN is defined.
module aff8_tap_accum
    import aff_filt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          frac_i,
    input  logic [8*PW-1:0]     prod_i,
    input  logic [SW-1:0]       ctr_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SW-1:0]       pix_o,
    output logic                frac0_o
`ifdef AFF_SAT_CNT_EN
    ,
    output logic [15:0]         sat_cnt_o
`endif
);

    logic                      adv;
    logic                      v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    s1_t                       s1_q, s1_d, s1_new;
    s2_t                       s2_q, s2_d;
    logic [SW-1:0]             pix_q, pix_d;
    logic                      frac0_q, frac0_d;
    logic [NTAP-1:0][AW-1:0]   term;
    logic [AW-1:0]             sum3;
    logic [SW-1:0]             rc_pix;

    // S1 input side: per-tap sign from the mask row, then pairwise sums.
    always_comb begin
        term = '0;
        for (int t = 0; t < NTAP; t++) begin
            term[t] = AW'($signed(prod_i[t*PW +: PW]));
            if (TAP_NEG[frac_i][t]) begin
                term[t] = -term[t];
            end
        end
        s1_new.frac0 = (frac_i == 4'd0);
        s1_new.ctr   = ctr_i;
        for (int k = 0; k < 4; k++) begin
            s1_new.sum[k] = term[2*k] + term[2*k+1];
        end
    end

    assign sum3 = s2_q.sum[0] + s2_q.sum[1];

`ifdef AFF_SAT_CNT_EN
    logic        rc_clip;
    logic        clip3_q, clip3_d;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    aff_round_clip u_round_clip (
        .sum_i  (sum3),
        .pix_c  (rc_pix),
        .clip_c (rc_clip)
    );
`else
    aff_round_clip u_round_clip (
        .sum_i  (sum3),
        .pix_c  (rc_pix)
    );
`endif

    // Whole pipe shifts together whenever the output slot is empty or being retired.
    always_comb begin
        adv     = ~v3_q | out_ready;
        v1_d    = v1_q;
        s1_d    = s1_q;
        v2_d    = v2_q;
        s2_d    = s2_q;
        v3_d    = v3_q;
        pix_d   = pix_q;
        frac0_d = frac0_q;
        if (adv) begin
            v1_d        = in_valid;
            s1_d        = s1_new;
            v2_d        = v1_q;
            s2_d.frac0  = s1_q.frac0;
            s2_d.ctr    = s1_q.ctr;
            s2_d.sum[0] = s1_q.sum[0] + s1_q.sum[1];
            s2_d.sum[1] = s1_q.sum[2] + s1_q.sum[3];
            v3_d        = v2_q;
            pix_d       = s2_q.frac0 ? s2_q.ctr : rc_pix;
            frac0_d     = s2_q.frac0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            pix_q   <= '0;
            frac0_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            pix_q   <= pix_d;
            frac0_q <= frac0_d;
        end
    end

`ifdef AFF_SAT_CNT_EN
    // Count clipped filter results as they retire; bypass results never count.
    always_comb begin
        clip3_d   = clip3_q;
        sat_cnt_d = sat_cnt_q;
        if (adv) begin
            clip3_d = rc_clip & ~s2_q.frac0;
        end
        if (v3_q && out_ready && clip3_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clip3_q   <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            clip3_q   <= clip3_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt_o = sat_cnt_q;
`endif

    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign pix_o     = pix_q;
    assign frac0_o   = frac0_q;

endmodule
